send_reg_axis: RTL and testbench

//  Serialiser that takes one 32-bit word over an AXI-Stream slave handshake and shifts it out
//  MSB-first on a two-wire clock/data LED bus (APA102/Blinkt style).

---
 rtl/send_reg_axis_pkg.sv | 16 +
 rtl/send_reg_axis_if.sv | 23 ++
 rtl/send_reg_axis_tick.sv | 40 ++++
 rtl/send_reg_axis.sv | 115 +++++++++++
 tb/tb_send_reg_axis.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/send_reg_axis_pkg.sv
// Shared types and sizing helpers for the send_reg_axis serialiser.
// States, plus the counter-width function used by the divider and bit counter.
package send_reg_axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_e;

    // A counter that only ever holds 0 still needs one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/send_reg_axis_if.sv
// AXI-Stream style word handshake into the LED serialiser.
// master drives data/valid, slave returns ready.
interface send_reg_axis_if #(
    parameter int DATA_WIDTH = 32
) ();

    logic [DATA_WIDTH-1:0] s_axis_data;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;

    modport master (
        output s_axis_data,
        output s_axis_tvalid,
        input  s_axis_tready
    );

    modport slave (
        input  s_axis_data,
        input  s_axis_tvalid,
        output s_axis_tready
    );

endinterface

// File: rtl/send_reg_axis_tick.sv
// Half-period divider: pulses tick_o on the last of every CLK_DIV enabled cycles.
// Latency: combinational pulse from the registered count; no backpressure.
module send_reg_axis_tick
    import send_reg_axis_pkg::*;
#(
    parameter int CLK_DIV = 120
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int            CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic [CW-1:0] div_cnt_d;

    assign tick_o = en_i && (div_cnt_q == LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (clr_i) begin
            div_cnt_d = '0;
        end else if (en_i) begin
            div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/send_reg_axis.sv
// Shifts one stream word out on an APA102-style clock/data pair (MSB-first, LSB-first with SEND_REG_AXIS_LSB_FIRST_EN).
// Latency: first LOW cycle follows accept; word takes 2*CLK_DIV*DATA_WIDTH cycles. Backpressure: tready low while busy.
module send_reg_axis
    import send_reg_axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 120
) (
    input  logic                i_clk,
    input  logic                i_reset,
    send_reg_axis_if.slave      s_axis,
    output logic                o_led_clk,
    output logic                o_led_data
);

    localparam int BW = cnt_width(DATA_WIDTH);

    state_e                state_q,   state_d;
    logic [DATA_WIDTH-1:0] shift_q,   shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tready_q,  tready_d;
    logic                  led_clk_q, led_clk_d;

    logic                  accept;
    logic                  tick;
    logic                  tick_en;
    logic [DATA_WIDTH-1:0] shifted;

    assign accept  = s_axis.s_axis_tvalid && tready_q;
    assign tick_en = (state_q != IDLE);

    // The shift register doubles as the data output flop; it is zeroed when idle.
`ifdef SEND_REG_AXIS_LSB_FIRST_EN
    assign shifted    = {1'b0, shift_q[DATA_WIDTH-1:1]};
    assign o_led_data = shift_q[0];
`else
    assign shifted    = {shift_q[DATA_WIDTH-2:0], 1'b0};
    assign o_led_data = shift_q[DATA_WIDTH-1];
`endif

    assign s_axis.s_axis_tready = tready_q;
    assign o_led_clk            = led_clk_q;

    send_reg_axis_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .en_i    (tick_en),
        .clr_i   (accept),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tready_d  = tready_q;
        led_clk_d = led_clk_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d   = s_axis.s_axis_data;
                    bit_cnt_d = BW'(DATA_WIDTH - 1);
                    tready_d  = 1'b0;
                    led_clk_d = 1'b0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (tick) begin
                    led_clk_d = 1'b1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (tick) begin
                    led_clk_d = 1'b0;
                    if (bit_cnt_q == '0) begin
                        shift_d  = '0;
                        tready_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q - BW'(1);
                        state_d   = LOW;
                    end
                end
            end
            default: begin
                shift_d   = '0;
                tready_d  = 1'b1;
                led_clk_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tready_q  <= 1'b1;
            led_clk_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tready_q  <= tready_d;
            led_clk_q <= led_clk_d;
        end
    end

endmodule

// File: tb/tb_send_reg_axis.sv
// Randomised scoreboard bench for send_reg_axis: a cycle-level reference model predicts
// tready/clk/data, and the expected bit stream is queued per accepted word.
module tb_send_reg_axis;

    localparam int DW       = 32;
    localparam int CD       = 2;
    localparam int WORD_CYC = 2 * CD * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic led_clk;
    logic led_data;

    send_reg_axis_if #(.DATA_WIDTH(DW)) axis ();

    send_reg_axis #(
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .s_axis     (axis),
        .o_led_clk  (led_clk),
        .o_led_data (led_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    int accepted = 0;

    bit exp_q[$];

    bit            m_busy = 1'b0;
    int            m_t    = 0;
    logic [DW-1:0] m_word = '0;
    logic          mon_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        failures++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Bit i (in transmission order) of a word.
    function automatic bit ref_bit(input logic [DW-1:0] w, input int i);
`ifdef SEND_REG_AXIS_LSB_FIRST_EN
        return w[i];
`else
        return w[DW-1-i];
`endif
    endfunction

    // Reference model: t counts cycles since the first LOW cycle of the word.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_t    = 0;
            exp_q.delete();
        end else begin
            check("tready", {31'd0, axis.s_axis_tready}, {31'd0, !m_busy});
            check("led_clk", {31'd0, led_clk},
                  m_busy ? 32'((m_t / CD) % 2) : 32'd0);
            check("led_data", {31'd0, led_data},
                  m_busy ? {31'd0, ref_bit(m_word, m_t / (2 * CD))} : 32'd0);
            if (m_busy) begin
                m_t++;
                if (m_t == WORD_CYC) m_busy = 1'b0;
            end else if (axis.s_axis_tvalid) begin
                m_busy = 1'b1;
                m_t    = 0;
                m_word = axis.s_axis_data;
                for (int b = 0; b < DW; b++) exp_q.push_back(ref_bit(m_word, b));
                accepted++;
            end
        end
    end

    // Scoreboard monitor: pops one expected bit per rising LED clock edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_prev = 1'b0;
        end else begin
            if (led_clk && !mon_prev) begin
                edges++;
                if (exp_q.size() == 0) begin
                    fail_msg("unexpected_led_edge");
                end else begin
                    check("sampled_bit", {31'd0, led_data}, {31'd0, exp_q.pop_front()});
                end
            end
            mon_prev = led_clk;
        end
    end

    task automatic wait_accept();
        int n0;
        n0 = accepted;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (accepted != n0) return;
        end
        fail_msg("accept_timeout");
    endtask

    task automatic send(input logic [DW-1:0] w);
        @(posedge clk);
        #1;
        axis.s_axis_data   = w;
        axis.s_axis_tvalid = 1'b1;
        wait_accept();
        #1;
        axis.s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!m_busy) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        fail_msg("drain_timeout");
    endtask

    initial begin
        int e0;
        int low_cnt;
        axis.s_axis_tvalid = 1'b0;
        axis.s_axis_data   = '0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_tready", {31'd0, axis.s_axis_tready}, 32'd1);
        check("rst_led_clk", {31'd0, led_clk}, 32'd0);
        check("rst_led_data", {31'd0, led_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle: no LED clock activity
        e0 = edges;
        repeat (1000) @(posedge clk);
        check("idle_edges", 32'(edges - e0), 32'd0);

        // Single word, 0xE0000000; tready low exactly one word time
        e0 = edges;
        send(32'hE000_0000);
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (axis.s_axis_tready) break;
            low_cnt++;
        end
        check("tready_low_cycles", 32'(low_cnt), 32'(WORD_CYC));
        drain();
        check("word_edges", 32'(edges - e0), 32'(DW));

        // Second word offered mid-word must wait
        e0 = edges;
        send(32'hA5A5_A5A5);
        repeat (50) @(posedge clk);
        send(32'hFFFF_FFFF);
        drain();
        check("midword_edges", 32'(edges - e0), 32'(2 * DW));

        // Back-to-back with tvalid held high
        e0 = edges;
        @(posedge clk);
        #1;
        axis.s_axis_data   = 32'h0000_0000;
        axis.s_axis_tvalid = 1'b1;
        wait_accept();
        #1 axis.s_axis_data = 32'hFFFF_FFFF;
        wait_accept();
        #1 axis.s_axis_tvalid = 1'b0;
        drain();
        check("b2b_edges", 32'(edges - e0), 32'(2 * DW));

        // Reset mid-word aborts; next word clean
        e0 = edges;
        send(32'h1234_5678);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (edges >= e0 + 10) break;
        end
        check("pre_reset_edges", 32'(edges - e0), 32'd10);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_tready", {31'd0, axis.s_axis_tready}, 32'd1);
        check("abort_led_clk", {31'd0, led_clk}, 32'd0);
        check("abort_led_data", {31'd0, led_data}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        e0 = edges;
        send(32'hC3C3_5A5A);
        drain();
        check("post_reset_edges", 32'(edges - e0), 32'(DW));

        // Single set bit exposes bit order
        send(32'h0000_0001);
        drain();

        // Random words, random gaps, ignored tvalid glitches while busy
        for (int n = 0; n < 15; n++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            send($urandom);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1;
                axis.s_axis_data   = $urandom;
                axis.s_axis_tvalid = 1'b1;
                @(posedge clk);
                #1 axis.s_axis_tvalid = 1'b0;
            end
        end
        drain();
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
